// File: rtl/des_key_schedule.sv
// des_key_schedule: DES round-subkey generator with valid/ready output handshake.
// Optional key parity error output when DES_KS_PARITY_CHECK_EN is defined.
module des_key_schedule #(
    parameter logic [15:0] SHIFT_MASK = 16'h8103
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    output logic [47:0] subkey_o,
    output logic [3:0]  subkey_round_o,
    output logic        subkey_valid_o,
    input  logic        subkey_ready_i,
    output logic        subkey_last_o,
    output logic        busy_o
`ifdef DES_KS_PARITY_CHECK_EN
    ,
    output logic        key_parity_err_o
`endif
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [55:0] pc1(input logic [63:0] k);
        for (int i = 0; i < 56; i++) pc1[55-i] = k[64-PC1_T[i]];
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        for (int i = 0; i < 48; i++) pc2[47-i] = cd[56-PC2_T[i]];
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        rotl = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        rotr = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dec_q, dec_d;
    logic        key_ready_q, key_ready_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic [47:0] subkey_q, subkey_d;
    logic [3:0]  round_q, round_d;

    logic        accept, adv, step, load, two;
    logic [3:0]  nxt, sh_idx;
    logic [55:0] cd_src;
    logic [27:0] c_new, d_new;

    always_comb begin
        accept  = key_valid_i & key_ready_q;
        adv     = valid_q & subkey_ready_i;
        step    = adv & ~last_q;
        load    = accept | step;
        nxt     = cnt_q + 4'd1;
        dec_d   = accept ? decrypt_i : dec_q;
        // Decrypt walks back through the schedule: step k undoes round 17-k.
        sh_idx  = accept ? 4'd0 : (dec_q ? 4'd15 - cnt_q : nxt);
        two     = ~SHIFT_MASK[sh_idx];
        cd_src  = accept ? pc1(key_i) : {c_q, d_q};
        c_new   = (accept & decrypt_i) ? cd_src[55:28] :
                  dec_d ? rotr(cd_src[55:28], two) : rotl(cd_src[55:28], two);
        d_new   = (accept & decrypt_i) ? cd_src[27:0] :
                  dec_d ? rotr(cd_src[27:0], two) : rotl(cd_src[27:0], two);
        c_d     = load ? c_new : c_q;
        d_d     = load ? d_new : d_q;
        cnt_d   = accept ? 4'd0 : step ? nxt : cnt_q;
        subkey_d = load ? pc2({c_new, d_new}) : subkey_q;
        round_d = load ? (dec_d ? 4'd15 - cnt_d : cnt_d) : round_q;
        last_d  = load ? (cnt_d == 4'd15) : adv ? 1'b0 : last_q;
        valid_d = accept ? 1'b1 : (adv & last_q) ? 1'b0 : valid_q;
        state_d = accept ? RUN : (adv & last_q) ? IDLE : state_q;
        key_ready_d = state_d == IDLE;
        busy_d  = state_d == RUN;
    end

`ifdef DES_KS_PARITY_CHECK_EN
    logic par_q, par_d;
    always_comb begin
        par_d = 1'b0;
        for (int b = 0; b < 8; b++) par_d = par_d | ~^key_i[8*b +: 8];
        par_d = par_d & accept;
    end
    always_ff @(posedge clk_i) par_q <= rst_n_i ? par_d : 1'b0;
    assign key_parity_err_o = par_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            c_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            dec_q       <= 1'b0;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            subkey_q    <= '0;
            round_q     <= '0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            dec_q       <= dec_d;
            key_ready_q <= key_ready_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            subkey_q    <= subkey_d;
            round_q     <= round_d;
        end
    end

    assign key_ready_o    = key_ready_q;
    assign busy_o         = busy_q;
    assign subkey_valid_o = valid_q;
    assign subkey_last_o  = last_q;
    assign subkey_o       = subkey_q;
    assign subkey_round_o = round_q;
endmodule
